// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and address type for the program counter
// Contents:
//   XLEN                 datapath width in bits
//   INSTR_BYTES          sequential PC increment
//   RESET_VECTOR_DEFAULT PC value loaded on reset
//   addr_t               XLEN-bit address type
package pc_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 64'h0;

  typedef logic [XLEN-1:0] addr_t;

endpackage

// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - control/datapath bundle between the control unit and the PC block
// Signals:
//   atualiza_pc  update enable (control unit -> PC)
//   soma_imm     next-address select: 1 = pc + imm, 0 = pc + INSTR_BYTES
//   imm          sign-extended byte offset
//   pc           registered current PC
//   pc_next      combinational next address
//   pc_plus4     combinational pc + INSTR_BYTES (link value)
//   misaligned   only with PC_MISALIGN_TRAP_EN: update blocked on misaligned target
// Modports: master = control unit side, slave = program_counter side.
interface program_counter_if #(
  parameter int XLEN = pc_pkg::XLEN
);

  logic            atualiza_pc;
  logic            soma_imm;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
  logic            misaligned;
`endif

  modport master (
    output atualiza_pc,
    output soma_imm,
    output imm,
    input  pc,
    input  pc_next,
    input  pc_plus4
`ifdef PC_MISALIGN_TRAP_EN
    , input misaligned
`endif
  );

  modport slave (
    input  atualiza_pc,
    input  soma_imm,
    input  imm,
    output pc,
    output pc_next,
    output pc_plus4
`ifdef PC_MISALIGN_TRAP_EN
    , output misaligned
`endif
  );

endinterface

// File: rtl/pc_next_adder.sv
// rtl/pc_next_adder.sv - combinational next-PC adder and select mux
// Ports:
//   i_pc        current PC
//   i_imm       sign-extended byte offset
//   i_soma_imm  1 = pc + imm, 0 = pc + INSTR_BYTES
//   o_pc_next   selected next address
//   o_pc_plus4  pc + INSTR_BYTES
// All sums wrap modulo 2^XLEN; there is deliberately no carry out.
module pc_next_adder #(
  parameter int XLEN        = pc_pkg::XLEN,
  parameter int INSTR_BYTES = pc_pkg::INSTR_BYTES
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_soma_imm,
  output logic [XLEN-1:0] o_pc_next,
  output logic [XLEN-1:0] o_pc_plus4
);

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_imm;

  // Two's complement add handles negative offsets with no extra logic.
  assign w_pc_plus4 = i_pc + XLEN'(INSTR_BYTES);
  assign w_pc_imm   = i_pc + i_imm;

  assign o_pc_plus4 = w_pc_plus4;
  assign o_pc_next  = i_soma_imm ? w_pc_imm : w_pc_plus4;

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - 64-bit RISC-V program counter register with next-address logic
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; loads RESET_VECTOR
//   bus    program_counter_if.slave (atualiza_pc, soma_imm, imm in; pc, pc_next, pc_plus4 out)
// Optional feature macro: PC_MISALIGN_TRAP_EN adds bus.misaligned and blocks
// updates whose target is not 4-byte aligned.
// Update priority per edge: reset, then atualiza_pc (unless blocked), else hold.
module program_counter
  import pc_pkg::*;
#(
  parameter int              XLEN         = pc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = pc_pkg::RESET_VECTOR_DEFAULT,
  parameter int              INSTR_BYTES  = pc_pkg::INSTR_BYTES
) (
  input logic              clk,
  input logic              reset,
  program_counter_if.slave bus
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_load;

  pc_next_adder #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_next_adder (
    .i_pc       (r_pc),
    .i_imm      (bus.imm),
    .i_soma_imm (bus.soma_imm),
    .o_pc_next  (w_pc_next),
    .o_pc_plus4 (w_pc_plus4)
  );

`ifdef PC_MISALIGN_TRAP_EN
  logic w_misaligned;

  // Flag only matters when an update is actually requested.
  assign w_misaligned   = bus.atualiza_pc & (w_pc_next[1:0] != 2'b00);
  assign bus.misaligned = w_misaligned;
  assign w_load         = bus.atualiza_pc & ~w_misaligned;
`else
  assign w_load         = bus.atualiza_pc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_VECTOR;
    end else if (w_load) begin
      r_pc <= w_pc_next;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.pc_next  = w_pc_next;
  assign bus.pc_plus4 = w_pc_plus4;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed table-driven bench for program_counter
module tb_program_counter;

  logic clk;
  logic reset;

  program_counter_if #(.XLEN(64)) bus ();

  program_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        atu;
    logic        soma;
    logic [63:0] imm;
    logic [63:0] e_pc;
    logic [63:0] e_next;
    logic [63:0] e_p4;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  int checks;
  int errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset           = 1'b0;
    bus.atualiza_pc = 1'b0;
    bus.soma_imm    = 1'b0;
    bus.imm         = 64'h0;

    // rst atu soma imm                    pc                     pc_next                pc_plus4 (after edge)
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 64'h0,                  64'h0,                 64'h4,                 64'h4};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h4,                 64'h8,                 64'h8};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h8,                 64'hC,                 64'hC};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'hC,                 64'h10,                64'h10};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4,                 64'hFFFF_FFFF_FFFF_FFFC, 64'h8};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 64'h100,                64'h104,               64'h204,               64'h108};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 64'h55,                 64'h104,               64'h108,               64'h108};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 64'h10,                 64'h104,               64'h114,               64'h108};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h104,               64'h100,               64'h108};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 64'h7,                  64'h104,               64'h108,               64'h108};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 64'h0,                  64'h104,               64'h104,               64'h108};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 64'h40,                 64'h0,                 64'h40,                64'h4};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h0,                 64'h4,                 64'h4};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h4,                 64'h8,                 64'h8};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 64'h0,                  64'h8,                 64'hC,                 64'hC};
`ifdef PC_MISALIGN_TRAP_EN
    vecs[16] = '{1'b0, 1'b1, 1'b1, 64'h2,                  64'h8,                 64'hA,                 64'hC};
`else
    vecs[16] = '{1'b0, 1'b1, 1'b1, 64'h2,                  64'hA,                 64'hC,                 64'hE};
`endif

    for (int i = 0; i < NV; i++) begin
      reset           = vecs[i].rst;
      bus.atualiza_pc = vecs[i].atu;
      bus.soma_imm    = vecs[i].soma;
      bus.imm         = vecs[i].imm;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i),       bus.pc,       vecs[i].e_pc);
      chk($sformatf("v%0d_pc_next", i),  bus.pc_next,  vecs[i].e_next);
      chk($sformatf("v%0d_pc_plus4", i), bus.pc_plus4, vecs[i].e_p4);
    end

`ifdef PC_MISALIGN_TRAP_EN
    chk("misaligned_high", {63'h0, bus.misaligned}, 64'h1);
    bus.atualiza_pc = 1'b0;
    #1;
    chk("misaligned_idle", {63'h0, bus.misaligned}, 64'h0);
    bus.imm = 64'h4;
    bus.atualiza_pc = 1'b1;
    #1;
    chk("misaligned_aligned", {63'h0, bus.misaligned}, 64'h0);
    bus.atualiza_pc = 1'b0;
    @(posedge clk);
    #1;
`endif

    // Combinational tracking with no clock edge in between.
    reset           = 1'b0;
    bus.atualiza_pc = 1'b0;
    bus.soma_imm    = 1'b1;
    bus.imm         = 64'h20;
    #1;
    chk("comb_imm", bus.pc_next, bus.pc + 64'h20);
    bus.soma_imm = 1'b0;
    #1;
    chk("comb_seq", bus.pc_next, bus.pc + 64'h4);

    // Hold with enable low across an edge, then a single reset with enable low.
    @(posedge clk);
    #1;
`ifdef PC_MISALIGN_TRAP_EN
    chk("hold_pc", bus.pc, 64'h8);
`else
    chk("hold_pc", bus.pc, 64'hA);
`endif
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_only_pc", bus.pc, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Program-counter block of the RISC-V datapath: a 64-bit PC register plus its next-address adder. Each update either advances the PC by one instruction (+4) or adds a signed immediate for branches and jumps. The control unit's state machine drives the update-enable and select inputs, typically pulsing the enable once per instruction during fetch.

## Interface
Parameters:
- XLEN, 64, datapath width in bits.
- RESET_VECTOR, 64'h0, PC value loaded on reset.
- INSTR_BYTES, 4, sequential increment.

Ports (one clock domain, `clk`; `reset` is synchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; loads RESET_VECTOR.
- atualiza_pc  in  1  update enable; PC loads pc_next on the rising edge while high.
- soma_imm  in  1  select: 1 = pc + imm, 0 = pc + INSTR_BYTES.
- imm  in  XLEN  signed byte offset (already sign-extended by decode).
- pc  out  XLEN  current PC, registered.
- pc_next  out  XLEN  combinational next address.
- pc_plus4  out  XLEN  combinational pc + INSTR_BYTES, for link writeback (jal/jalr).

## Operation
- pc_plus4 = pc + INSTR_BYTES.
- pc_next = soma_imm ? (pc + imm) : pc_plus4.
- All additions are modulo 2^XLEN; wrap-around is silent, with no carry or overflow output.
- imm is two's complement, so negative offsets move backward.
- Register update priority, on each rising edge:
  - reset → pc = RESET_VECTOR.
  - else atualiza_pc → pc = pc_next.
  - else pc holds.
- reset overrides atualiza_pc when both are high on the same edge.
- soma_imm and imm are sampled only through pc_next at the edge where atualiza_pc is high. They are don't-care otherwise.
- No internal FSM; sequencing is owned by the control unit.

## Timing
- pc reset value: RESET_VECTOR, visible the cycle after the reset edge. pc_next and pc_plus4 then follow combinationally from it.
- Update latency: 1 cycle. The pc_next computed in cycle N appears on pc after the edge that ends cycle N.
- Combinational path imm/soma_imm → pc_next has no register; the path pc → pc_next is a single 64-bit adder stage.
- Reset asserted mid-sequence discards any pending update on that edge.
- Holding atualiza_pc high for consecutive cycles advances the PC every cycle.

## Configuration
- Macro `PC_MISALIGN_TRAP_EN`.
- When defined:
  - Adds output `misaligned` (out, 1 bit), combinational: atualiza_pc & (pc_next[1:0] != 2'b00).
  - While misaligned is high, the update is suppressed and pc holds.
  - Reset still has priority.
- When undefined:
  - No misaligned port.
  - pc_next loads unchanged, including its low bits.

## Structure
- Shared package (`pc_pkg`):
  - XLEN and INSTR_BYTES constants.
  - RESET_VECTOR default.
  - An `addr_t` typedef (logic [XLEN-1:0]).
- One sub-module, `pc_next_adder`, holds the combinational adder and mux. Its ports are pc in, imm, soma_imm, pc_next, and pc_plus4.
- The top level holds the register, the priority logic and the optional misalignment check.

## Test plan
- Reset: assert reset with atualiza_pc=1 → pc=0x0 after the edge, pc_plus4=0x4.
- Sequential: soma_imm=0, atualiza_pc=1 for 3 cycles from 0 → pc=0x4, 0x8, 0xC.
- Branch: pc=0xC, soma_imm=1, imm=0xFFFF_FFFF_FFFF_FFF8 (−8), one enable pulse → pc=0x4; then imm=0x100 → pc=0x104.
- Hold: atualiza_pc=0 for 5 cycles with soma_imm and imm toggling → pc unchanged, while pc_next tracks its inputs.
- Wrap: from 0, imm=0xFFFF_FFFF_FFFF_FFFC with soma_imm=1 → pc=0xFFFF_FFFF_FFFF_FFFC; then soma_imm=0 → pc=0x0.
- Misaligned (macro defined): pc=0x8, soma_imm=1, imm=0x2, atualiza_pc=1 → misaligned=1 and pc stays 0x8. With the macro undefined, the same stimulus → pc=0xA.
